aes_key_expand: RTL

Iterative AES-128 key schedule sitting directly upstream of the round datapath. It takes the 128-bit cipher key and computes the eleven round keys (k0..k10), one per clock. It holds them in an internal bank that the chained round stages and the final round index by round number. It signals completion with a held `done` level so the round pipeline can launch only after every key it needs is present.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes_key_expand.sv | 137 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule constants, block/word types, GF(2^8) helpers.
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [1:0] {
    KX_IDLE   = 2'd0,
    KX_EXPAND = 2'd1,
    KX_DONE   = 2'd2
  } kx_state_e;

  // GF(2^8) doubling with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box for one byte; shared by the key schedule and round datapath.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Row-major table, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] msb_pos;

  assign msb_pos  = 11'd2047 - {in_byte, 3'b000};
  assign out_byte = SBOX_FLAT[msb_pos -: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-slot bank.
// Optional AES_KEY_ZEROIZE_EN adds a zeroize input that wipes the bank and returns to IDLE.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter bit READ_REG = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic        zeroize,
`endif
  input  logic        start,
  input  logic [127:0] key_in,
  input  logic [3:0]  rd_idx,
  output logic [127:0] rk_out,
  output logic        busy,
  output logic        done
);

  kx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rcon_q, rcon_d;
  aes_block_t bank_q [0:NR];
  aes_block_t bank_d [0:NR];

  aes_block_t prev_key;
  aes_block_t next_key;
  aes_word_t  rot_w;
  aes_word_t  sub_w;
  aes_word_t  t_w;
  aes_word_t  n0, n1, n2, n3;
  aes_block_t rk_d;

  // Previous round key bank[cnt-1]; explicit mux keeps cnt=0 from indexing out of range.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NR; i++) begin
      if (cnt_q == 4'(i + 1)) prev_key = bank_q[i];
    end
  end

  assign rot_w = {prev_key[23:0], prev_key[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < NK; gi++) begin : g_subword
      aes_sbox u_sbox (
        .in_byte  (rot_w[8*gi +: 8]),
        .out_byte (sub_w[8*gi +: 8])
      );
    end
  endgenerate

  assign t_w      = sub_w ^ {rcon_q, 24'h0};
  assign n0       = prev_key[127:96] ^ t_w;
  assign n1       = prev_key[95:64]  ^ n0;
  assign n2       = prev_key[63:32]  ^ n1;
  assign n3       = prev_key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    for (int i = 0; i <= NR; i++) bank_d[i] = bank_q[i];

    case (state_q)
      KX_IDLE, KX_DONE: begin
        if (start) begin
          bank_d[0] = key_in;
          cnt_d     = 4'd1;
          rcon_d    = RCON_INIT;
          state_d   = KX_EXPAND;
        end
      end
      KX_EXPAND: begin
        for (int i = 1; i <= NR; i++) begin
          if (cnt_q == 4'(i)) bank_d[i] = next_key;
        end
        cnt_d  = cnt_q + 4'd1;
        rcon_d = xtime(rcon_q);
        if (cnt_q == 4'(NR)) state_d = KX_DONE;
      end
      default: state_d = KX_IDLE;
    endcase

`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize overrides any start or expansion write on the same edge.
    if (zeroize) begin
      state_d = KX_IDLE;
      cnt_d   = '0;
      rcon_d  = '0;
      for (int i = 0; i <= NR; i++) bank_d[i] = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= KX_IDLE;
      cnt_q   <= '0;
      rcon_q  <= RCON_INIT;
      for (int i = 0; i <= NR; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      for (int i = 0; i <= NR; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign busy = (state_q == KX_EXPAND);
  assign done = (state_q == KX_DONE);

  // Indices 11..15 have no slot and read as zero.
  always_comb begin
    rk_d = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_idx == 4'(i)) rk_d = bank_q[i];
    end
  end

  generate
    if (READ_REG) begin : g_rd_reg
      aes_block_t rk_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rk_q <= '0;
        else     rk_q <= rk_d;
      end
      assign rk_out = rk_q;
    end else begin : g_rd_comb
      assign rk_out = rk_d;
    end
  endgenerate

endmodule
